fetch_prefetch_stage: RTL
=========================

# fetch_prefetch_stage

Parametrised instruction-fetch front end for the OpenPiton L1.5 transducer port, successor to the single-word blocking fetch stage. Fetches whole 16-byte lines with IMISS requests, holds the current line in a line buffer, and streams sequential instructions into a QDEPTH-entry instruction queue feeding decode at up to one instruction per cycle. Redirects (branch/jump/exception) flush the queue, reuse the line buffer on a tag hit, and drop stale in-flight responses.

## Interface
- RESET_PC, 32'h4000_0000, fetch PC after reset and while asleep
- QDEPTH, 4, instruction-queue entries; power of two, >= 2
- NOP_INSTR, 32'h0000_0033, instruction presented when queue empty
- clk  in  1  clock; all state changes on rising edge
- nrst  in  1  reset; synchronous, active-low
- redirect_val  in  1  load redirect_pc; flushes queue
- redirect_pc  in  32  new fetch PC
- out_ready  in  1  decode accepts head entry this cycle
- out_val  out  1  queue non-empty
- out_instr  out  32  head instruction (byte-swapped), NOP_INSTR when empty
- out_pc  out  32  head PC; fetch_pc when empty
- out_misaligned  out  1  head entry carries instruction-address-misaligned
- transducer_l15_rqtype  out  5  5'b10000 (IMISS) when val, else 0
- transducer_l15_size  out  3  3'b000
- transducer_l15_address  out  32  {fetch_pc[31:4], 4'b0}
- transducer_l15_data  out  64  always 0
- transducer_l15_val  out  1  request valid
- l15_transducer_header_ack  in  1  request header accepted
- l15_transducer_ack  in  1  request fully accepted
- l15_transducer_val  in  1  response valid
- l15_transducer_data_0 / _1  in  64 each  response line words 0-1 / 2-3
- l15_transducer_returntype  in  4  response type
- transducer_l15_req_ack  out  1  response consumed

## Operation
- FSM states: SLEEP, IDLE, REQ, WAIT_ACK, RESP. Reset -> SLEEP, fetch_pc=RESET_PC, queue empty, line buffer invalid, drop=0.
- SLEEP: l15_transducer_val with returntype 4'b0111 (INT_RET) -> IDLE; req_ack=1 that cycle. No requests while asleep.
- IDLE: if line buffer valid and tag==fetch_pc[31:4] and queue not full: push {fetch_pc, word, misaligned=0}, fetch_pc+=4. If tag mismatch/invalid and not halted -> REQ.
- REQ: val=1; header_ack -> ack ? RESP : WAIT_ACK. WAIT_ACK: ack -> RESP.
- RESP: val with returntype IFILL_RET(0001) or LOAD_RET(0000): req_ack=1; if drop=0 write line buffer, tag=fetch_pc[31:4], valid=1; drop<=0; -> IDLE. Other returntypes with val: req_ack=1, ignored, stay.
- Word k of line: k=0 data_0[63:32], 1 data_0[31:0], 2 data_1[63:32], 3 data_1[31:0]; bytes reversed {w[7:0],w[15:8],w[23:16],w[31:24]}.
- Redirect (any state except SLEEP): flush queue, fetch_pc=redirect_pc, halted=0. In REQ before header_ack: address switches to new line next cycle (val stays high). In WAIT_ACK/RESP: drop<=1; transaction completes and is discarded; FSM returns IDLE then REQs new line. Line buffer kept; reused if tag matches.
- Misaligned redirect (redirect_pc[1:0]!=0): push one entry {redirect_pc, NOP_INSTR, misaligned=1}, set halted; no fetches until next redirect.
- Pop when out_val && out_ready. Push and pop same cycle allowed when full (pop frees slot).
- Redirect coinciding with pop or response: redirect wins; popped entry is lost (decode flushes too); response obeys drop.
- fetch_pc wraps 32'hFFFF_FFFC -> 0.

## Timing
- Redirect at edge N: queue empty at N+1; on line hit, first entry pushed at N+1, out_val=1 from N+2.
- Miss: val asserted from the cycle after entering REQ; response at edge M -> first push M+1, out_val M+2; then 1 push/cycle until line end or full.
- transducer_l15_req_ack combinational, same cycle as l15_transducer_val.
- Reset outputs: out_val=0, out_instr=NOP_INSTR, out_pc=RESET_PC, out_misaligned=0, all transducer_l15_* = 0.

## Structure
- Package fetch_pkg: returntype constants (LOAD_RET, IFILL_RET, INT_RET), IMISS_RQ, NOP_INSTR default, FSM state enum, queue entry struct {pc, instr, misaligned}.
- Sub-module fetch_queue: QDEPTH synchronous FIFO with push, pop, flush, full, empty; flush has priority over push.

## Test plan
- Reset, INT_RET wake, response line 0x00000013/0x00100093/0x00200113/0x00300193 (byte-swapped on bus) -> one IMISS to 0x4000_0000; out_pc 0x4000_0000..0x4000_000C, one per cycle with out_ready=1.
- out_ready=0, QDEPTH=4 -> queue holds 4 entries, no extra push; release -> in-order drain, next IMISS to 0x4000_0010.
- Redirect to 0x4000_0008 with line valid -> no request; out_pc 0x4000_0008 two cycles later.
- Redirect to 0x8000_0000 during WAIT_ACK -> old response acked and dropped; next IMISS to 0x8000_0000; no stale instruction reaches out_*.
- Redirect to 0x4000_0002 -> single entry misaligned=1, instr 0x33; no further requests until redirect.
- Response with returntype 0100 in RESP -> req_ack=1, ignored; subsequent IFILL_RET fills line.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the prefetching instruction-fetch front end:
//   - L1.5 response return types and the IMISS request type
//   - default NOP encoding presented when the instruction queue is empty
//   - fetch FSM state encoding
//   - instruction-queue entry layout {pc, instr, misaligned}
//   - byte_swap helper: the L1.5 delivers instruction words big-endian on the
//     bus, the core expects them little-endian
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [3:0]  LOAD_RET          = 4'b0000;
  localparam logic [3:0]  IFILL_RET         = 4'b0001;
  localparam logic [3:0]  INT_RET           = 4'b0111;
  localparam logic [4:0]  IMISS_RQ          = 5'b10000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0033;

  typedef enum logic [2:0] {
    ST_SLEEP,
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_RESP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } qentry_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// QDEPTH-entry synchronous FIFO of fetched instructions.
// Ports:
//   clk_i, nrst_i   clock, synchronous active-low reset (pointers only)
//   flush_i         empty the queue; overrides push and pop this cycle
//   push_i/entry_i  write entry_i at the tail (accepted when not full, or when
//                   a pop frees the slot in the same cycle)
//   pop_i           drop the head entry (ignored when empty)
//   head_o          head entry; contents undefined when empty_o
//   full_o, empty_o occupancy flags
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic    clk_i,
  input  logic    nrst_i,
  input  logic    flush_i,
  input  logic    push_i,
  input  qentry_t entry_i,
  input  logic    pop_i,
  output qentry_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(QDEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        do_push;
  logic        do_pop;
  qentry_t     mem_q [QDEPTH];

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count == DEPTH_W);
  assign empty_o = (count == '0);

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is pure data: no reset, validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_stage
// Instruction-fetch front end for the OpenPiton L1.5 transducer port. Fetches
// 16-byte lines with IMISS requests into a one-line buffer and streams
// sequential instructions from it into a QDEPTH-entry queue feeding decode.
// Ports:
//   clk, nrst                  clock, synchronous active-low reset
//   redirect_val/redirect_pc   load a new fetch PC and flush the queue
//   out_ready                  decode consumes the head entry this cycle
//   out_val/out_instr/out_pc/out_misaligned
//                              head of the instruction queue (NOP_INSTR and
//                              fetch PC when empty)
//   transducer_l15_*           IMISS request channel to the L1.5
//   l15_transducer_*           request acks and response channel from the L1.5
//   transducer_l15_req_ack     response consumed (combinational)
// -----------------------------------------------------------------------------
module fetch_prefetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter int          QDEPTH    = 4,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_val,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_misaligned,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_val,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_val,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  input  logic [3:0]  l15_transducer_returntype,
  output logic        transducer_l15_req_ack
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         line_vld_q, line_vld_d;
  logic         drop_q, drop_d;
  logic         halted_q, halted_d;
  logic         mis_pend_q, mis_pend_d;
  logic [27:0]  tag_q;
  logic [31:0]  line_q [4];
  logic         line_wr;

  logic         q_push;
  logic         q_flush;
  logic         q_full;
  logic         q_empty;
  qentry_t      q_entry;
  qentry_t      q_head;

  logic         pop_fire;
  logic         can_push;
  logic         line_hit;
  logic         resp_fill;
  logic         redir;
  logic         redir_mis;
  logic         req_ack;

  assign pop_fire  = out_ready && !q_empty;
  // A pop in the same cycle frees the slot a full queue needs for the push.
  assign can_push  = !q_full || pop_fire;
  assign line_hit  = line_vld_q && (tag_q == fetch_pc_q[31:4]);
  assign resp_fill = l15_transducer_val &&
                     ((l15_transducer_returntype == IFILL_RET) ||
                      (l15_transducer_returntype == LOAD_RET));
  assign redir     = redirect_val && (state_q != ST_SLEEP);
  assign redir_mis = |redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    line_vld_d = line_vld_q;
    drop_d     = drop_q;
    halted_d   = halted_q;
    mis_pend_d = mis_pend_q;
    line_wr    = 1'b0;
    req_ack    = 1'b0;
    q_flush    = 1'b0;
    q_push     = 1'b0;
    q_entry    = '{pc: fetch_pc_q, instr: line_q[fetch_pc_q[1+2:2]], misaligned: 1'b0};

    // The misaligned marker goes in the cycle after the redirect, once the
    // flush has emptied the queue; it is the only entry until the next redirect.
    if (mis_pend_q) begin
      q_push  = 1'b1;
      q_entry = '{pc: fetch_pc_q, instr: NOP_INSTR, misaligned: 1'b1};
      if (can_push) mis_pend_d = 1'b0;
    end

    case (state_q)
      ST_SLEEP: begin
        if (l15_transducer_val && (l15_transducer_returntype == INT_RET)) begin
          req_ack = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!halted_q) begin
          if (line_hit) begin
            if (can_push) begin
              q_push     = 1'b1;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (l15_transducer_header_ack) begin
          state_d = l15_transducer_ack ? ST_RESP : ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (l15_transducer_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        // Every response is consumed; only fills complete the transaction.
        if (l15_transducer_val) begin
          req_ack = 1'b1;
          if (resp_fill) begin
            if (!drop_q) begin
              line_wr    = 1'b1;
              line_vld_d = 1'b1;
            end
            drop_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_SLEEP;
    endcase

    // Redirect overrides any push/pop this cycle. An already-accepted request
    // must still run to completion, so its response is marked for discard.
    if (redir) begin
      q_flush    = 1'b1;
      q_push     = 1'b0;
      fetch_pc_d = redirect_pc;
      halted_d   = redir_mis;
      mis_pend_d = redir_mis;
      case (state_q)
        ST_REQ: begin
          if (l15_transducer_header_ack) drop_d = 1'b1;
          else if (redir_mis)            state_d = ST_IDLE;
        end
        ST_WAIT_ACK: drop_d = 1'b1;
        ST_RESP:     if (!resp_fill) drop_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= ST_SLEEP;
      fetch_pc_q <= RESET_PC;
      line_vld_q <= 1'b0;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
      mis_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      line_vld_q <= line_vld_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
      mis_pend_q <= mis_pend_d;
    end
  end

  // Line buffer and tag are data, qualified by line_vld_q. Fetch PC does not
  // move while a miss is outstanding, so it still names the requested line.
  always_ff @(posedge clk) begin
    if (line_wr) begin
      tag_q     <= fetch_pc_q[31:4];
      line_q[0] <= byte_swap(l15_transducer_data_0[63:32]);
      line_q[1] <= byte_swap(l15_transducer_data_0[31:0]);
      line_q[2] <= byte_swap(l15_transducer_data_1[63:32]);
      line_q[3] <= byte_swap(l15_transducer_data_1[31:0]);
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .nrst_i  (nrst),
    .flush_i (q_flush),
    .push_i  (q_push),
    .entry_i (q_entry),
    .pop_i   (out_ready),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign out_val        = !q_empty;
  assign out_instr      = q_empty ? NOP_INSTR  : q_head.instr;
  assign out_pc         = q_empty ? fetch_pc_q : q_head.pc;
  assign out_misaligned = !q_empty && q_head.misaligned;

  assign transducer_l15_val     = (state_q == ST_REQ);
  assign transducer_l15_rqtype  = transducer_l15_val ? IMISS_RQ : 5'b00000;
  assign transducer_l15_address = transducer_l15_val ? {fetch_pc_q[31:4], 4'b0000} : 32'h0;
  assign transducer_l15_size    = 3'b000;
  assign transducer_l15_data    = 64'h0;
  assign transducer_l15_req_ack = req_ack;

endmodule
